// File: rtl/shift_sub_divider_pkg.sv
// Shared types and defaults for the shift/subtract divider block.
// Imported by the divider top, its trial subtractor and its bus interface.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SUB,
        S_DONE
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Run/done switch-style bus for the divider: operands in, results and status out.
// The master side (lab top level or bench) drives run and operands; the divider is the slave.
interface shift_sub_divider_if #(
    parameter int unsigned WIDTH = divider_pkg::DIV_WIDTH_DEFAULT
);

    logic             run;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output run, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  run, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/shift_sub_divider_trial_sub.sv
// Trial subtraction for one restoring-division step: partial remainder minus divisor.
// borrow set means the divisor did not fit and the caller keeps the old remainder.
module trial_sub #(
    parameter int unsigned WIDTH = divider_pkg::DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    logic [WIDTH+1:0] t;

    // One extra bit above the remainder width captures the borrow.
    assign t      = {1'b0, r} - {2'b00, d};
    assign diff   = t[WIDTH:0];
    assign borrow = t[WIDTH+1];

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: captures operands on run, iterates WIDTH shift/trial-subtract
// steps, then holds quotient/remainder until the next start. Divide-by-zero short-circuits.
module shift_sub_divider #(
    parameter int unsigned WIDTH = divider_pkg::DIV_WIDTH_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    shift_sub_divider_if.slave   bus
);

    import divider_pkg::*;

    localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t state, next_state;

    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             zero_div;

    assign zero_div = (bus.divisor == '0);

    trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .r      (r_q),
        .d      (d_q),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.run) begin
                    next_state = zero_div ? S_DONE : S_SHIFT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_SHIFT: next_state = S_SUB;
            S_SUB:   next_state = (cnt_q == LAST) ? S_DONE : S_SHIFT;
            // A run level still high after completion must not restart the operation.
            S_DONE:  next_state = bus.run ? S_DONE : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        if (!zero_div) begin
                            r_q   <= '0;
                            q_q   <= bus.dividend;
                            d_q   <= bus.divisor;
                            cnt_q <= '0;
                            dbz_q <= 1'b0;
                        end else begin
                            r_q   <= {1'b0, bus.dividend};
                            q_q   <= '1;
                            dbz_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
                end
                S_SUB: begin
                    if (!borrow) begin
                        r_q    <= diff;
                        q_q[0] <= 1'b1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q[WIDTH-1:0];
    assign bus.busy        = (state == S_SHIFT) || (state == S_SUB);
    assign bus.done        = (state == S_DONE);
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized checks of shift_sub_divider against plain integer division.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_sub_divider;

    localparam int LIMIT = 60;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    shift_sub_divider_if #(.WIDTH(8)) bus ();

    shift_sub_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input int n, input int d, output int q, output int r);
        if (d == 0) begin
            q = 255;
            r = n;
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // Starts an operation, waits (bounded) for done, holds run for extra cycles, then releases
    // run and lets the block return to idle.
    task automatic do_op(input logic [7:0] n, input logic [7:0] d, input int extra_hold,
                         input bit scramble, output int lat, output bit saw_busy,
                         output int held_done);
        @(negedge clk);
        bus.dividend = n;
        bus.divisor  = d;
        bus.run      = 1'b1;
        lat          = 0;
        saw_busy     = 1'b0;
        held_done    = 0;
        while (lat < LIMIT) begin
            @(negedge clk);
            lat++;
            if (bus.busy) saw_busy = 1'b1;
            if (bus.done) break;
            if (scramble) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 8'($urandom);
            end
        end
        check("done_within_bound", bus.done, 1);
        for (int i = 0; i < extra_hold; i++) begin
            @(negedge clk);
            if (bus.done && !bus.busy) held_done++;
        end
        bus.run = 1'b0;
        @(negedge clk);
    endtask

    task automatic op_and_check(input string tag, input logic [7:0] n, input logic [7:0] d,
                                input int extra_hold, input bit scramble);
        int lat, held, q, r;
        bit saw_busy;
        ref_div(int'(n), int'(d), q, r);
        do_op(n, d, extra_hold, scramble, lat, saw_busy, held);
        check({tag, "_latency"}, lat, (d == 0) ? 1 : 17);
        check({tag, "_quotient"}, bus.quotient, q);
        check({tag, "_remainder"}, bus.remainder, r);
        check({tag, "_dbz"}, bus.div_by_zero, (d == 0) ? 1 : 0);
        check({tag, "_idle_done"}, bus.done, 0);
        check({tag, "_held_done"}, held, extra_hold);
        if (d == 0) check({tag, "_busy_seen"}, saw_busy, 0);
    endtask

    initial begin
        int lat, held, q, r;
        bit saw_busy;
        logic [7:0] n, d;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.run      = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (2) @(negedge clk);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        reset = 1'b0;

        op_and_check("d100_7", 8'd100, 8'd7, 3, 1'b0);
        op_and_check("d255_1", 8'd255, 8'd1, 1, 1'b0);
        op_and_check("d5_200", 8'd5, 8'd200, 1, 1'b0);
        op_and_check("d200_200", 8'd200, 8'd200, 1, 1'b0);
        op_and_check("d37_0", 8'd37, 8'd0, 1, 1'b0);
        op_and_check("scramble", 8'd100, 8'd7, 1, 1'b1);
        op_and_check("hold_run", 8'd100, 8'd7, 10, 1'b0);
        op_and_check("d9_4", 8'd9, 8'd4, 1, 1'b0);

        // Abort five cycles into an operation.
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.run      = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        reset   = 1'b0;
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        check("post_abort_busy", bus.busy, 0);
        check("post_abort_done", bus.done, 0);
        op_and_check("after_abort", 8'd100, 8'd7, 1, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            n = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(1, 255));
            ref_div(int'(n), int'(d), q, r);
            do_op(n, d, 0, 1'b0, lat, saw_busy, held);
            check("rand_quotient", bus.quotient, q);
            check("rand_remainder", bus.remainder, r);
            check("rand_identity",
                  ((int'(bus.quotient) * int'(d) + int'(bus.remainder)) == int'(n)) &&
                  (int'(bus.remainder) < int'(d)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
